// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core with a unified instruction/data memory, a single ALU
// and a Moore control FSM; instructions take 2-5 cycles depending on their class.
module multicycle_cpu #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] dataaddr,
    output logic [31:0] writedata,
    output logic        memwrite
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic [31:0] regs [32];
    logic [31:0] mem [MEM_WORDS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, rs_val, rt_val, mem_addr, mem_rdata, alu_result;
    logic        funct_ok, rf_we, mem_we, unused_bits;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[5:0];
    assign simm        = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val      = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val      = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign mem_addr    = (state_q == S_FETCH) ? pc_q : alu_out_q;
    assign mem_rdata   = mem[mem_addr[AW+1:2]];
    assign unused_bits = ^{mem_addr[31:AW+2], mem_addr[1:0], ir_q[10:6]};

    assign pc        = pc_q;
    assign dataaddr  = alu_out_q;
    assign writedata = b_q;
    assign memwrite  = mem_we;

    // funct_ok doubles as the legality check used by DECODE for R-type words
    always_comb begin
        alu_result = 32'd0;
        funct_ok   = 1'b1;
        case (funct)
            FN_ADD:  alu_result = a_q + b_q;
            FN_SUB:  alu_result = a_q - b_q;
            FN_AND:  alu_result = a_q & b_q;
            FN_OR:   alu_result = a_q | b_q;
            FN_SLT:  alu_result = {31'd0, $signed(a_q) < $signed(b_q)};
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;
        mem_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d       = rs_val;
                b_d       = rt_val;
                alu_out_d = pc_q + {simm[29:0], 2'b00};
                case (opcode)
                    OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_FETCH;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_out_d = a_q + simm;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mdr_d   = mem_rdata;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_out_d = alu_result;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_out_q;
                state_d = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_out_d = a_q + simm;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= 32'd0;
            ir_q      <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Memory contents survive reset; only the core state is cleared
    always_ff @(posedge clk) begin
        if (mem_we) mem[alu_out_q[AW+1:2]] <= b_q;
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench: an instruction-level model predicts per-cycle pc/memwrite and
// the ALUOut/store values, and a single compare process checks the core against it.
module tb_multicycle_cpu;
    typedef struct {
        logic [31:0] pc;
        logic        mw;
        logic        chk_da;
        logic [31:0] da;
        logic        chk_wd;
        logic [31:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc, dataaddr, writedata;
    logic        memwrite;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          mw_count = 0;
    int          total = 0;
    logic        running = 1'b0;
    exp_t        exp_q[$];
    exp_t        cur;

    logic [31:0] img   [64];
    logic [31:0] m_mem [64];
    logic [31:0] m_regs[32];
    logic [31:0] m_pc;

    multicycle_cpu #(.MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .pc(pc), .dataaddr(dataaddr),
        .writedata(writedata), .memwrite(memwrite)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 32'd0;
    endtask

    task automatic load_image();
        for (int i = 0; i < 64; i++) begin
            dut.mem[i] = img[i];
            m_mem[i]   = img[i];
        end
    endtask

    task automatic m_write(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) m_regs[idx] = v;
    endtask

    // Architectural model: executes whole instructions, then expands each into its cycles
    task automatic model_run(input int n_instr);
        logic [31:0] instr, start, rsv, rtv, simm, res, target, prev_da;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic        do_sw, valid;
        int          ncyc;
        exp_t        e;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        prev_da = 32'd0;
        for (int n = 0; n < n_instr; n++) begin
            instr  = m_mem[m_pc[7:2]];
            op     = instr[31:26];
            rs     = instr[25:21];
            rt     = instr[20:16];
            rd     = instr[15:11];
            fn     = instr[5:0];
            simm   = {{16{instr[15]}}, instr[15:0]};
            start  = m_pc;
            rsv    = m_regs[rs];
            rtv    = m_regs[rt];
            target = start + 32'd4 + (simm << 2);
            m_pc   = start + 32'd4;
            ncyc   = 2;
            res    = target;
            do_sw  = 1'b0;
            case (op)
                6'h00: begin
                    valid = 1'b1;
                    case (fn)
                        6'h20:   res = rsv + rtv;
                        6'h22:   res = rsv - rtv;
                        6'h24:   res = rsv & rtv;
                        6'h25:   res = rsv | rtv;
                        6'h2A:   res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                        default: valid = 1'b0;
                    endcase
                    if (valid) begin
                        ncyc = 4;
                        m_write(rd, res);
                    end
                end
                6'h23: begin
                    ncyc = 5;
                    res  = rsv + simm;
                    m_write(rt, m_mem[res[7:2]]);
                end
                6'h2B: begin
                    ncyc  = 4;
                    res   = rsv + simm;
                    do_sw = 1'b1;
                end
                6'h04: begin
                    ncyc = 3;
                    if (rsv == rtv) m_pc = target;
                end
                6'h08: begin
                    ncyc = 4;
                    res  = rsv + simm;
                    m_write(rt, res);
                end
                6'h02: begin
                    ncyc = 3;
                    m_pc = {m_pc[31:28], instr[25:0], 2'b00};
                end
                default: ncyc = 2;
            endcase
            for (int k = 0; k < ncyc; k++) begin
                e.pc     = (k == 0) ? start : start + 32'd4;
                e.mw     = do_sw && (k == 3);
                e.chk_da = (k == 0);
                e.da     = prev_da;
                e.chk_wd = 1'b0;
                e.wd     = 32'd0;
                if (e.mw) begin
                    e.chk_da = 1'b1;
                    e.da     = res;
                    e.chk_wd = 1'b1;
                    e.wd     = rtv;
                end
                exp_q.push_back(e);
            end
            if (do_sw) m_mem[res[7:2]] = rtv;
            prev_da = res;
        end
        e.pc = m_pc; e.mw = 1'b0; e.chk_da = 1'b1; e.da = prev_da; e.chk_wd = 1'b0; e.wd = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic start_program(input int n_instr);
        load_image();
        exp_q.delete();
        model_run(n_instr);
        total    = exp_q.size();
        cyc      = 0;
        mw_count = 0;
        @(posedge clk);
        #1 reset   = 1'b1;
        running = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++)
            check32($sformatf("%s_reg%0d", tag, i), dut.regs[i], m_regs[i]);
    endtask

    task automatic stop_program();
        running = 1'b0;
        reset   = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (running && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check32($sformatf("pc@%0d", cyc), pc, cur.pc);
            check32($sformatf("memwrite@%0d", cyc), {31'd0, memwrite}, {31'd0, cur.mw});
            if (cur.chk_da) check32($sformatf("dataaddr@%0d", cyc), dataaddr, cur.da);
            if (cur.chk_wd) check32($sformatf("writedata@%0d", cyc), writedata, cur.wd);
            if (memwrite) mw_count++;
            cyc++;
        end
    end

    initial begin
        // Reset and branch sequence
        clear_img();
        img[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        img[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd6);
        img[2] = enc_i(6'h04, 5'd2, 5'd3, 16'd1);
        img[3] = enc_i(6'h08, 5'd2, 5'd2, 16'd1);
        img[4] = enc_i(6'h04, 5'd2, 5'd3, 16'd1);
        img[5] = enc_i(6'h08, 5'd2, 5'd2, 16'd1);
        img[6] = enc_r(5'd2, 5'd0, 5'd4, 6'h20);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_pc", pc, 32'd0);
        check32("rst_memwrite", {31'd0, memwrite}, 32'd0);
        check32("rst_dataaddr", dataaddr, 32'd0);
        check32("rst_writedata", writedata, 32'd0);
        start_program(6);
        repeat (2) @(negedge clk);
        #1 check32("first_edge_pc", pc, 32'd4);
        repeat (total - 2) @(negedge clk);
        #1;
        check32("br_pc", pc, 32'd28);
        check32("br_dataaddr", dataaddr, 32'd6);
        check32("br_r4", dut.regs[4], 32'd6);
        check32("br_r2_skip", dut.regs[2], 32'd6);
        check_regs("br");
        stop_program();

        // Store then load through memory
        clear_img();
        img[0] = enc_i(6'h08, 5'd0, 5'd5, 16'd77);
        img[1] = enc_i(6'h2B, 5'd0, 5'd5, 16'd40);
        img[2] = enc_i(6'h23, 5'd0, 5'd6, 16'd40);
        img[3] = enc_r(5'd6, 5'd0, 5'd7, 6'h20);
        start_program(4);
        repeat (total) @(negedge clk);
        #1;
        check32("mem_mw_cycles", mw_count, 32'd1);
        check32("mem_r7", dut.regs[7], 32'd77);
        check32("mem_dataaddr", dataaddr, 32'd77);
        check_regs("mem");
        stop_program();

        // ALU operations, wrap-around and undefined encodings
        clear_img();
        img[0]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        img[1]  = enc_i(6'h08, 5'd0, 5'd3, 16'd5);
        img[2]  = enc_r(5'd2, 5'd3, 5'd4, 6'h22);
        img[3]  = enc_r(5'd2, 5'd3, 5'd5, 6'h24);
        img[4]  = enc_r(5'd2, 5'd3, 5'd6, 6'h25);
        img[5]  = enc_r(5'd2, 5'd3, 5'd7, 6'h2A);
        img[6]  = enc_r(5'd3, 5'd2, 5'd12, 6'h2A);
        img[7]  = enc_i(6'h23, 5'd0, 5'd8, 16'd160);
        img[8]  = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
        img[9]  = enc_r(5'd8, 5'd9, 5'd10, 6'h20);
        img[10] = enc_r(5'd2, 5'd3, 5'd11, 6'h21);
        img[11] = enc_i(6'h0D, 5'd0, 5'd14, 16'h0055);
        img[40] = 32'h7FFF_FFFF;
        start_program(12);
        repeat (total) @(negedge clk);
        #1;
        check32("alu_sub", dut.regs[4], 32'hFFFF_FFF8);
        check32("alu_and", dut.regs[5], 32'd5);
        check32("alu_or", dut.regs[6], 32'hFFFF_FFFD);
        check32("alu_slt_neg", dut.regs[7], 32'd1);
        check32("alu_slt_pos", dut.regs[12], 32'd0);
        check32("alu_wrap", dut.regs[10], 32'h8000_0000);
        check32("alu_bad_funct", dut.regs[11], 32'd0);
        check32("alu_bad_op", dut.regs[14], 32'd0);
        check32("alu_pc", pc, 32'd48);
        check_regs("alu");
        stop_program();

        // Jump and writes to $0
        clear_img();
        img[0]  = {6'h02, 26'h10};
        img[16] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        img[17] = enc_r(5'd0, 5'd0, 5'd13, 6'h20);
        start_program(3);
        repeat (4) @(negedge clk);
        #1 check32("jump_pc", pc, 32'h40);
        repeat (total - 4) @(negedge clk);
        #1;
        check32("zero_reg", dut.regs[0], 32'd0);
        check32("zero_read", dataaddr, 32'd0);
        check_regs("jmp");
        stop_program();

        // Asynchronous reset in the middle of a load
        clear_img();
        img[0]  = enc_i(6'h08, 5'd0, 5'd5, 16'd99);
        img[1]  = enc_i(6'h2B, 5'd0, 5'd5, 16'd160);
        img[2]  = enc_i(6'h23, 5'd0, 5'd6, 16'd164);
        img[41] = 32'h0000_1234;
        start_program(2);
        repeat (12) @(negedge clk);
        #1;
        check32("lw_mid_pc", pc, 32'd12);
        running = 1'b0;
        reset   = 1'b0;
        #1;
        check32("async_pc", pc, 32'd0);
        check32("async_memwrite", {31'd0, memwrite}, 32'd0);
        check32("async_dataaddr", dataaddr, 32'd0);
        check32("async_writedata", writedata, 32'd0);
        check32("async_rt", dut.regs[6], 32'd0);
        check32("async_mem_kept", dut.mem[40], 32'd99);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 check32("restart_pc0", pc, 32'd0);
        @(negedge clk);
        #1 check32("restart_pc4", pc, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
